// File: rtl/zero_frame_stats_if.sv
// Handshake and result bus for zero_frame_stats.
// master: upstream word source plus result consumer (drives words, takes results).
// slave : the statistics block itself.
interface zero_frame_stats_if #(
  parameter int SUM_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       count0;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] frame_zeros;
  logic [7:0]       zero_words;
  logic [3:0]       max_zeros;
  logic             err;

  modport master (
    output in_valid, count0, in_last, out_ready,
    input  in_ready, out_valid, frame_zeros, zero_words, max_zeros, err
  );

  modport slave (
    input  in_valid, count0, in_last, out_ready,
    output in_ready, out_valid, frame_zeros, zero_words, max_zeros, err
  );
endinterface

// File: rtl/zero_frame_stats.sv
// zero_frame_stats: per-frame statistics over upstream per-word zero counts.
// A frame ends after FRAME_LEN accepted words or on an accepted in_last.
// Results appear one cycle after the final accept and are held until taken.
// Optional feature macro: ZERO_FRAME_STATS_MAX_EN enables max_zeros tracking;
// without it max_zeros reads 0 and no register is built for it.
module zero_frame_stats #(
  parameter int FRAME_LEN = 16,   // words per frame, 1..255
  parameter int SUM_W     = 8     // frame_zeros width, >= 4
)(
  input  logic               clk,
  input  logic               rst_n,
  zero_frame_stats_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           r_state;
  logic [7:0]       r_cnt;      // words accepted in the current frame
  logic [SUM_W-1:0] r_sum;      // running saturating zero sum
  logic [7:0]       r_zw;       // running count of all-zero words
  logic [SUM_W-1:0] r_fz;       // registered results
  logic [7:0]       r_zwo;
  logic             r_vld;
  logic             r_err;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_first;
  logic [3:0]       w_c8;
  logic [SUM_W:0]   w_sum_ext;
  logic [SUM_W-1:0] w_sum_nxt;
  logic [7:0]       w_zw_nxt;
  logic [7:0]       w_cnt_nxt;
  logic             w_end;

`ifdef ZERO_FRAME_STATS_MAX_EN
  logic [3:0]       r_max;
  logic [3:0]       r_mx;
  logic [3:0]       w_max_base;
  logic [3:0]       w_max_nxt;
`endif

  // The block is only blocked while a result waits for the consumer, which
  // also guarantees no word is taken in the handoff cycle.
  assign w_in_ready = (r_state != HOLD);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_first    = (r_state == IDLE);

  // Next-value datapath: an illegal count (>8) is clamped to 8 everywhere.
  // In IDLE the accumulators are taken as zero so the first word loads.
  always_comb begin
    w_c8      = (bus.count0 > 4'd8) ? 4'd8 : bus.count0;
    w_sum_ext = {1'b0, (w_first ? {SUM_W{1'b0}} : r_sum)} + (SUM_W+1)'(w_c8);
    w_sum_nxt = w_sum_ext[SUM_W] ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];
    w_zw_nxt  = (w_first ? 8'd0 : r_zw) + {7'd0, (w_c8 == 4'd8)};
    w_cnt_nxt = (w_first ? 8'd0 : r_cnt) + 8'd1;
    w_end     = bus.in_last || (w_cnt_nxt == 8'(FRAME_LEN));
  end

`ifdef ZERO_FRAME_STATS_MAX_EN
  // Running maximum of clamped counts.
  always_comb begin
    w_max_base = w_first ? 4'd0 : r_max;
    w_max_nxt  = (w_c8 > w_max_base) ? w_c8 : w_max_base;
  end
`endif

  // Frame FSM with accumulators and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_sum   <= '0;
      r_zw    <= 8'd0;
      r_fz    <= '0;
      r_zwo   <= 8'd0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
`ifdef ZERO_FRAME_STATS_MAX_EN
      r_max   <= 4'd0;
      r_mx    <= 4'd0;
`endif
    end else begin
      // Sticky: only reset clears it.
      if (w_accept && (bus.count0 > 4'd8)) r_err <= 1'b1;

      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            r_sum <= w_sum_nxt;
            r_zw  <= w_zw_nxt;
            r_cnt <= w_cnt_nxt;
`ifdef ZERO_FRAME_STATS_MAX_EN
            r_max <= w_max_nxt;
`endif
            if (w_end) begin
              r_fz    <= w_sum_nxt;
              r_zwo   <= w_zw_nxt;
`ifdef ZERO_FRAME_STATS_MAX_EN
              r_mx    <= w_max_nxt;
`endif
              r_vld   <= 1'b1;
              r_state <= HOLD;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        HOLD: begin
          // Result outputs keep their value; only valid drops on handoff.
          if (bus.out_ready) begin
            r_vld   <= 1'b0;
            r_cnt   <= 8'd0;
            r_sum   <= '0;
            r_zw    <= 8'd0;
`ifdef ZERO_FRAME_STATS_MAX_EN
            r_max   <= 4'd0;
`endif
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_vld;
  assign bus.frame_zeros = r_fz;
  assign bus.zero_words  = r_zwo;
  assign bus.err         = r_err;
`ifdef ZERO_FRAME_STATS_MAX_EN
  assign bus.max_zeros   = r_mx;
`else
  assign bus.max_zeros   = 4'd0;
`endif

endmodule

// File: tb/tb_zero_frame_stats.sv
// Directed bench for zero_frame_stats (FRAME_LEN=16, SUM_W=8).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_zero_frame_stats;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  zero_frame_stats_if #(.SUM_W(8)) bus();

  zero_frame_stats #(.FRAME_LEN(16), .SUM_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // max_zeros only carries the maximum when the feature is built in.
  function automatic int emax(input int m);
`ifdef ZERO_FRAME_STATS_MAX_EN
    return m;
`else
    return (m == 0) ? 0 : 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for one cycle.
  task automatic send(input int c, input bit last);
    bus.in_valid = 1'b1;
    bus.count0   = 4'(c);
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_res(input string tag, input int fz, input int zw, input int mx);
    chk({tag, ".vld"}, int'(bus.out_valid),   1);
    chk({tag, ".fz"},  int'(bus.frame_zeros), fz);
    chk({tag, ".zw"},  int'(bus.zero_words),  zw);
    chk({tag, ".mx"},  int'(bus.max_zeros),   emax(mx));
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.count0 = 4'd0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst.vld", int'(bus.out_valid),   0);
    chk("rst.fz",  int'(bus.frame_zeros), 0);
    chk("rst.zw",  int'(bus.zero_words),  0);
    chk("rst.mx",  int'(bus.max_zeros),   0);
    chk("rst.err", int'(bus.err),         0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst.rdy", int'(bus.in_ready), 1);

    // Full 16-word frame of 3s
    bus.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) send(3, 1'b0);
    chk("f16.early", int'(bus.out_valid), 0);
    send(3, 1'b0);
    chk_res("f16", 48, 0, 3);
    chk("f16.rdy0", int'(bus.in_ready), 0);
    tick();
    chk("f16.hand", int'(bus.out_valid), 0);
    chk("f16.rdy1", int'(bus.in_ready), 1);

    // Early terminator: 8,0,5
    send(8, 1'b0);
    send(0, 1'b0);
    chk("last.early", int'(bus.out_valid), 0);
    send(5, 1'b1);
    chk_res("last", 13, 1, 8);
    tick();
    chk("last.hand", int'(bus.out_valid), 0);

    // Back-pressure in HOLD with a pending upstream word
    bus.out_ready = 1'b0;
    send(2, 1'b0);
    send(4, 1'b1);
    chk_res("hold", 6, 0, 4);
    bus.in_valid = 1'b1;
    bus.count0   = 4'd7;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold.rdy", int'(bus.in_ready), 0);
      chk_res("hold.stb", 6, 0, 4);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("hold.hand", int'(bus.out_valid), 0);
    chk("hold.rdy1", int'(bus.in_ready), 1);
    tick();  // pending word 7 now accepted once as a one-word frame
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk_res("nopass", 7, 0, 7);
    tick();

    // Illegal count is clamped and sets sticky err
    send(12, 1'b0);
    send(1, 1'b1);
    chk_res("clamp", 9, 1, 8);
    chk("clamp.err", int'(bus.err), 1);
    tick();
    send(2, 1'b1);
    chk_res("sticky", 2, 0, 2);
    chk("sticky.err", int'(bus.err), 1);
    tick();

    // Reset mid-frame after 7 accepts
    for (int i = 0; i < 7; i++) send(5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.vld", int'(bus.out_valid),   0);
    chk("mrst.fz",  int'(bus.frame_zeros), 0);
    chk("mrst.zw",  int'(bus.zero_words),  0);
    chk("mrst.mx",  int'(bus.max_zeros),   0);
    chk("mrst.err", int'(bus.err),         0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst.rdy", int'(bus.in_ready), 1);
    // Word counter must have restarted: frame ends at word 16, not 9.
    for (int i = 0; i < 9; i++) send(1, 1'b0);
    chk("mrst.cnt", int'(bus.out_valid), 0);
    for (int i = 0; i < 7; i++) send(1, 1'b0);
    chk_res("mrst.f", 16, 0, 1);
    tick();

    // All-zero words across a full frame
    for (int i = 0; i < 16; i++) send(8, 1'b0);
    chk_res("all8", 128, 16, 8);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/zero_frame_stats.md
ZERO_FRAME_STATS -- requirements
Module: zero_frame_stats

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, giving the number of words per frame (legal range 1..255).
REQ-002 SHALL have parameter SUM_W, default 8, giving the width of frame_zeros.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: count0 and in_last are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-007 SHALL have port count0, input, 4 bits: zero count of one 8-bit word from the upstream zero-counting stage.
REQ-008 SHALL have port in_last, input, 1 bit: early frame terminator.
REQ-009 SHALL have port out_valid, output, 1 bit: frame result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port frame_zeros, output, SUM_W bits: total zeros in the frame.
REQ-012 SHALL have port zero_words, output, 8 bits: number of words in the frame with count0 == 8.
REQ-013 SHALL have port max_zeros, output, 4 bits: largest count0 seen in the frame.
REQ-014 SHALL have port err, output, 1 bit: sticky flag, set when count0 > 8 was accepted.

Function
REQ-015 SHALL implement the states IDLE, ACCUM and HOLD.
REQ-016 SHALL drive in_ready = 1 in IDLE and ACCUM, and in_ready = 0 in HOLD.
REQ-017 SHALL define an accept as in_valid && in_ready at a rising clk edge.
REQ-018 SHALL, on an accept in IDLE, load the accumulators with the first word and go to ACCUM; if that word also ends the frame, it SHALL go to HOLD.
REQ-019 SHALL, on each accept in ACCUM, add count0 to the running sum, increment zero_words when count0 == 8, and update the running maximum.
REQ-020 SHALL end a frame on the accept that is word number FRAME_LEN, or on any accept with in_last = 1, whichever comes first.
REQ-021 SHALL, at frame end, register the results into the output ports and assert out_valid in the cycle after the final accept (1-cycle latency).
REQ-022 SHALL hold out_valid and all result outputs stable in HOLD until out_ready = 1.
REQ-023 SHALL, on out_valid && out_ready, deassert out_valid, clear the accumulators and word counter, and go to IDLE; in_ready SHALL rise in the following cycle.
REQ-024 SHALL accept no word in the same cycle as an out_ready handoff, so there is no pass-through.
REQ-025 SHALL treat an accepted count0 > 8 as 8 for every statistic and set err; err SHALL clear only on reset.
REQ-026 SHALL saturate frame_zeros at all-ones rather than wrap when SUM_W is too narrow.
REQ-027 SHALL ignore in_valid when in_ready = 0; such data is not consumed.
REQ-028 SHALL ignore in_last outside an accept.

Reset
REQ-029 SHALL, on rst_n low, immediately force state IDLE, out_valid = 0, frame_zeros = 0, zero_words = 0, max_zeros = 0, err = 0, and clear the word counter.
REQ-030 SHALL, on reset mid-frame or in HOLD, discard the partial frame or pending result with no output.
REQ-031 SHALL drive in_ready = 1 on the first clk edge after rst_n deasserts.

Configuration
REQ-032 SHALL, when macro ZERO_FRAME_STATS_MAX_EN is defined, implement the max_zeros tracking described above.
REQ-033 SHALL, when ZERO_FRAME_STATS_MAX_EN is undefined, keep the max_zeros port but tie it to 0 and omit its register; all other behaviour is unchanged.

Verification
REQ-034 SHALL cover: FRAME_LEN=16, sixteen accepts with count0=3 and out_ready=1 -> next cycle out_valid=1, frame_zeros=48, zero_words=0, max_zeros=3.
REQ-035 SHALL cover: count0 sequence 8,0,5 with in_last on the third word -> frame_zeros=13, zero_words=1, max_zeros=8, out_valid one cycle after the third accept.
REQ-036 SHALL cover: out_ready held 0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0 and outputs stable throughout; after out_ready=1, IDLE and in_ready=1 on the next cycle.
REQ-037 SHALL cover: count0=12 accepted -> counted as 8 and err=1; err remains 1 across later frames until rst_n is pulsed low.
REQ-038 SHALL cover: rst_n pulsed low after 7 accepts -> out_valid=0 and all outputs 0 at once; the next frame sums only post-reset words.
REQ-039 SHALL cover: build without ZERO_FRAME_STATS_MAX_EN, frame with count0 up to 7 -> max_zeros=0 and other results identical to the build with the macro.
